// File: rtl/alu_ctrl_pkg.sv
// Shared types and default widths for the two-requester ALU controller.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int OP_W_DEF   = 3;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_ctrl_state_t;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one
// that was not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic       grant_id,
  output logic       grant_vld
);

  always_comb begin
    grant_vld = en & (|valid);
    if (valid == 2'b11) grant_id = ~last_grant;
    else                grant_id = valid[1];
  end

endmodule

// File: rtl/alu_rr_controller.sv
// Arbitrates two requesters onto one combinational ALU: operands are
// registered, the result is captured and returned on a tagged response port.
module alu_rr_controller
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  alu_ctrl_state_t   state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic grant_id;
  logic grant_vld;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .en         (state_q == IDLE),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld)
  );

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld &  grant_id;

  always_comb begin
    // NOTE: every next-state value starts as a copy of its flop so no path
    // through the case leaves it unassigned (which would infer a latch).
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    ops_done_d   = ops_done_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          alu_a_d      = grant_id ? req1_a  : req0_a;
          alu_b_d      = grant_id ? req1_b  : req0_b;
          alu_op_d     = grant_id ? req1_op : req0_op;
          grant_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_id_d    = grant_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;

endmodule
